// File: rtl/check_syntax_alu.sv
// check_syntax_alu: registered 8-bit two-operand ALU, one operation per clock, latency 1.
// reset_n is active-high despite its name.
package check_syntax_alu_pkg;
  localparam int DATA_W = 8;
  localparam int CTRL_W = 3;
  typedef struct packed {
    logic [CTRL_W-1:0] control_in;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
  } port;
  typedef struct packed {
    logic [2*DATA_W-1:0] result;
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic valid;
  } o_port;
endpackage

module check_syntax_alu
  import check_syntax_alu_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  port   port_1,
  output o_port port_o
);
  localparam logic [CTRL_W-1:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_AND = 3'd3,
                                OP_OR = 3'd4, OP_XOR = 3'd5, OP_SHL = 3'd6;
  logic [DATA_W-1:0] w_a, w_b;
  logic [CTRL_W-1:0] w_op;
  logic [DATA_W:0] w_sum, w_dif;
  logic [2*DATA_W-1:0] w_mul, w_shl, w_shr, w_res;
  logic w_carry, w_ovf;
  o_port r_out;
  assign w_a = port_1.a_in;
  assign w_b = port_1.b_in;
  assign w_op = port_1.control_in;
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_dif = {1'b0, w_a} - {1'b0, w_b};
  assign w_mul = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};
  assign w_shl = {{DATA_W{1'b0}}, w_a} << w_b[2:0];
  // a sits in the upper byte so the bits shifted out of it land in the lower byte
  assign w_shr = {w_a, {DATA_W{1'b0}}} >> w_b[2:0];
  always_comb begin
    w_res = '0;
    w_carry = 1'b0;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = {{(DATA_W-1){1'b0}}, w_sum};
        w_carry = w_sum[DATA_W];
        w_ovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);
      end
      OP_SUB: begin
        w_res = {{DATA_W{1'b0}}, w_dif[DATA_W-1:0]};
        w_carry = w_dif[DATA_W];
        w_ovf = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_dif[DATA_W-1] != w_a[DATA_W-1]);
      end
      OP_MUL: w_res = w_mul;
      OP_AND: w_res = {{DATA_W{1'b0}}, w_a & w_b};
      OP_OR:  w_res = {{DATA_W{1'b0}}, w_a | w_b};
      OP_XOR: w_res = {{DATA_W{1'b0}}, w_a ^ w_b};
      OP_SHL: begin
        w_res = w_shl;
        w_carry = |w_shl[2*DATA_W-1:DATA_W];
      end
      default: begin
        w_res = {{DATA_W{1'b0}}, w_shr[2*DATA_W-1:DATA_W]};
        w_carry = |w_shr[DATA_W-1:0];
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset_n) r_out <= '0;
    else begin
      r_out.result <= w_res;
      r_out.carry <= w_carry;
      r_out.zero <= ~|w_res;
      r_out.negative <= (w_op == OP_MUL) ? w_res[2*DATA_W-1] : w_res[DATA_W-1];
      r_out.overflow <= w_ovf;
      r_out.valid <= 1'b1;
    end
  end
  assign port_o = r_out;
endmodule

// File: tb/tb_check_syntax_alu.sv
// tb_check_syntax_alu: table vectors plus random stream, checked through an expected-result queue.
module tb_check_syntax_alu;
  import check_syntax_alu_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  port port_1 = '0;
  o_port port_o;
  int total = 0, bad = 0;
  typedef struct { port in; o_port exp; } vec_t;
  typedef struct { o_port exp; string tag; } sb_t;
  sb_t q[$];
  vec_t vecs[11];

  check_syntax_alu dut (.clock(clock), .reset_n(reset_n), .port_1(port_1), .port_o(port_o));

  always #5 clock = ~clock;

  function automatic vec_t mk(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic [15:0] r,
                              logic c, logic z, logic n, logic v);
    vec_t t;
    t.in.control_in = op; t.in.a_in = a; t.in.b_in = b;
    t.exp.result = r; t.exp.carry = c; t.exp.zero = z;
    t.exp.negative = n; t.exp.overflow = v; t.exp.valid = 1'b1;
    return t;
  endfunction

  function automatic o_port model(port p);
    o_port o;
    int a, b, sa, sb, sh, r;
    bit c, v;
    a = p.a_in; b = p.b_in; sa = $signed(p.a_in); sb = $signed(p.b_in); sh = p.b_in[2:0];
    r = 0; c = 0; v = 0;
    case (p.control_in)
      3'd0: begin r = a + b; c = r > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = (a - b) & 255; c = a < b; v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = a * b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin r = a << sh; c = r > 255; end
      default: begin r = a >> sh; c = (a & ((1 << sh) - 1)) != 0; end
    endcase
    o.result = r[15:0];
    o.carry = c;
    o.zero = (r == 0);
    o.negative = (p.control_in == 3'd2) ? r[15] : r[7];
    o.overflow = v;
    o.valid = 1'b1;
    return o;
  endfunction

  function automatic port rnd_in();
    port p;
    p.control_in = 3'($urandom_range(7));
    p.a_in = 8'($urandom_range(255));
    p.b_in = 8'($urandom_range(255));
    return p;
  endfunction

  task automatic check_front();
    sb_t s;
    s = q.pop_front();
    total++;
    if (port_o !== s.exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", s.tag, port_o, s.exp);
    end
  endtask

  // new inputs go in just after the edge, the previous result is checked a step later
  task automatic drive(input logic rst, input port p, input o_port exp, input string tag);
    sb_t s;
    @(posedge clock);
    #1;
    reset_n = rst;
    port_1 = p;
    #1;
    if (q.size() > 0) check_front();
    s.exp = exp; s.tag = tag;
    q.push_back(s);
  endtask

  initial begin
    port p;
    vecs[0]  = mk(3'd0, 8'hF0, 8'h20, 16'h0110, 1, 0, 0, 0);
    vecs[1]  = mk(3'd0, 8'h7F, 8'h01, 16'h0080, 0, 0, 1, 1);
    vecs[2]  = mk(3'd1, 8'h10, 8'h20, 16'h00F0, 1, 0, 1, 0);
    vecs[3]  = mk(3'd1, 8'h55, 8'h55, 16'h0000, 0, 1, 0, 0);
    vecs[4]  = mk(3'd2, 8'hFF, 8'hFF, 16'hFE01, 0, 0, 1, 0);
    vecs[5]  = mk(3'd5, 8'hAA, 8'hAA, 16'h0000, 0, 1, 0, 0);
    vecs[6]  = mk(3'd3, 8'hF0, 8'h3C, 16'h0030, 0, 0, 0, 0);
    vecs[7]  = mk(3'd6, 8'h81, 8'h03, 16'h0408, 1, 0, 0, 0);
    vecs[8]  = mk(3'd7, 8'h81, 8'hF9, 16'h0040, 1, 0, 0, 0);
    vecs[9]  = mk(3'd4, 8'h0F, 8'hF0, 16'h00FF, 0, 0, 1, 0);
    vecs[10] = mk(3'd6, 8'h80, 8'h08, 16'h0080, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_in(), '0, $sformatf("reset%0d", i));
    p = rnd_in();
    drive(1'b0, p, model(p), "release");
    for (int i = 0; i < 11; i++) drive(1'b0, vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++) begin
      p = rnd_in();
      if (i == 5) drive(1'b1, p, '0, "midreset");
      else drive(1'b0, p, model(p), $sformatf("stream%0d", i));
    end
    @(posedge clock);
    #2;
    check_front();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/check_syntax_alu.md
Name: check_syntax_alu

Overview:
- Registered 8-bit two-operand ALU.
- Takes a packed input bundle of type `port` (opcode plus two operands) and returns a packed result/flag bundle of type `o_port`.
- Sits as a leaf datapath block: no handshake beyond an output valid flag, and a new operation is accepted every clock.

Parameters:
- DATA_W, 8, operand width. Package constant; must match the `port`/`o_port` typedefs.
- CTRL_W, 3, opcode width. Package constant.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  reset. Synchronous and active-high despite the `_n` suffix: 1 = reset.
- port_1  input  19 (packed `port`)  fields, MSB to LSB:
  - control_in[2:0]: opcode
  - a_in[7:0]: operand A
  - b_in[7:0]: operand B
- port_o  output  21 (packed `o_port`)  fields, MSB to LSB:
  - result[15:0]
  - carry
  - zero
  - negative
  - overflow
  - valid

Behaviour:
- Single pipeline stage.
  - At each rising edge with reset_n=0, port_1 is sampled, the operation is evaluated combinationally, and all port_o fields are registered.
  - Latency is 1 clock; throughput is 1 operation per clock.
- Reset (reset_n=1 at a rising edge): every port_o field is cleared to 0, including valid. Reset has priority over any input.
  - Reset mid-stream discards the in-flight result.
  - The first result after reset is the one computed at the first edge where reset_n=0.
- valid: 0 during and directly out of reset; 1 on every edge where reset_n=0.
- Opcodes (unsigned operands unless noted):
  - 000 ADD: result = {7'b0, a+b (9-bit)}; carry = sum bit 8; overflow = signed 8-bit overflow.
  - 001 SUB: result = {8'b0, (a-b) mod 256}; carry = borrow (1 when a<b); overflow = signed 8-bit overflow.
  - 010 MUL: result = a*b, full unsigned 16-bit product; carry=0; overflow=0.
  - 011 AND, 100 OR, 101 XOR: result = {8'b0, a op b}; carry=0; overflow=0.
  - 110 SHL: result = {8'b0,a} << b[2:0], with shifted-out bits retained in result[15:8]; carry = OR of result[15:8]; overflow=0.
  - 111 SHR: result = {8'b0, a >> b[2:0]} (logical); carry = OR of the bits shifted out of a; overflow=0.
- Flags:
  - zero = (result == 0), evaluated on the full 16-bit result.
  - negative: result[7] for all ops except MUL; result[15] for MUL.
- b_in[7:3] is ignored for the shift opcodes.
- No X propagation into registered outputs. Every opcode value is defined, so there is no illegal-opcode case.
- Inputs may change every cycle. Only the value present at the sampling edge matters; there is no input holding requirement.

Test Plan:
- Reset: hold reset_n=1 for 3 edges with random inputs -> port_o == 0 (valid=0) after each edge. Release -> valid=1 on the next edge.
- ADD carry/overflow:
  - A=F0, B=20, op=000 -> result=0110, carry=1, overflow=0, zero=0.
  - A=7F, B=01 -> result=0080, overflow=1, negative=1, carry=0.
- SUB borrow: A=10, B=20, op=001 -> result=00F0, carry=1, negative=1, overflow=0.
  - A=55, B=55 -> result=0000, zero=1, carry=0.
- MUL and logic:
  - A=FF, B=FF, op=010 -> result=FE01, negative=1.
  - A=AA, B=AA, op=101 -> result=0000, zero=1.
  - A=F0, B=3C, op=011 -> result=0030.
- Shifts:
  - A=81, B=03, op=110 -> result=0408, carry=1.
  - A=81, B=F9, op=111 -> result=0040, carry=1 (only b[2:0]=1 is used).
- Back-to-back and mid-stream reset:
  - Change the opcode and operands on every edge for 10 cycles -> each result appears exactly one edge after its sampling, matching a reference model.
  - Assert reset_n=1 for one edge mid-sequence -> port_o=0 after that edge, and the stream resumes correctly on the next edge.
